decoder_n_pipe: RTL and testbench

//  Parametrised, registered N-to-2^N decoder with a valid/ready stream interface.

---
 rtl/decoder_n_pipe.sv | 126 ++++++++++++
 tb/tb_decoder_n_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decoder_n_pipe
// Description : Registered N-to-2^N decoder with a valid/ready stream
//               interface. Produces one-hot, thermometer or active-low
//               one-hot codes from din, or runs a self-timed one-hot scan
//               (digit/row strobe) at a programmable step rate.
// Revision    : 1.0  initial release
// ============================================================================
module decoder_n_pipe #(
  parameter int N_IN     = 2,   // select width, 1..5
  parameter int SCAN_DIV = 4    // cycles per scan step, >= 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN-1:0]        din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(2**N_IN)-1:0]   dout
);

  localparam int c_OUT_W = 2 ** N_IN;
  localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_OUT_W-1:0] c_ONE      = {{(c_OUT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_MODE_ONEHOT  = 2'b00;
  localparam logic [1:0] c_MODE_THERM   = 2'b01;
  localparam logic [1:0] c_MODE_SCAN    = 2'b10;
  localparam logic [1:0] c_MODE_ONEHOTN = 2'b11;

  // Output register and scan state
  logic                 r_valid;
  logic [c_OUT_W-1:0]   r_dout;
  logic [N_IN-1:0]      r_pos;
  logic [c_DIV_W-1:0]   r_div;

  // Combinational helpers
  logic                 w_scan;
  logic                 w_free;
  logic                 w_pop;
  logic                 w_accept;
  logic                 w_tick;
  logic [c_OUT_W-1:0]   w_onehot;
  logic [c_OUT_W-1:0]   w_therm;
  logic [c_OUT_W-1:0]   w_scan_word;
  logic [c_OUT_W-1:0]   w_code;

  assign w_scan   = (mode == c_MODE_SCAN);
  // The register can take a new word if it is empty or being drained now.
  assign w_free   = !r_valid || out_ready;
  assign w_pop    = r_valid && out_ready;
  assign in_ready = rst_n && en && !w_scan && w_free;
  assign w_accept = in_valid && in_ready;
  // Terminal count of the step divider; stays asserted while a step is pending.
  assign w_tick   = (r_div == c_DIV_LAST);

  assign out_valid = r_valid;
  assign dout      = r_dout;

  // Thermometer bit i is set for every position at or below the select.
  generate
    for (genvar gi = 0; gi < c_OUT_W; gi++) begin : g_therm
      assign w_therm[gi] = (32'(gi) <= 32'(din));
    end
  endgenerate

  // Decode din according to the requested code and form the scan word
  always_comb begin
    w_onehot    = c_ONE << din;
    w_scan_word = c_ONE << r_pos;
    w_code      = w_onehot;
    case (mode)
      c_MODE_ONEHOT:  w_code = w_onehot;
      c_MODE_THERM:   w_code = w_therm;
      c_MODE_ONEHOTN: w_code = ~w_onehot;
      default:        w_code = w_onehot;
    endcase
  end

  // Output register, scan position and step divider
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      // Reset and disable both flush the register and restart the scan.
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_pos   <= '0;
      r_div   <= '0;
    end else if (w_scan) begin
      if (w_tick) begin
        if (w_free) begin
          r_valid <= 1'b1;
          r_dout  <= w_scan_word;
          r_pos   <= r_pos + 1'b1;
          r_div   <= '0;
        end
        // Stalled: divider parks at terminal count so the step is not lost.
      end else begin
        r_div <= r_div + 1'b1;
        if (w_pop) begin
          r_valid <= 1'b0;
          r_dout  <= '0;
        end
      end
    end else begin
      // Outside scan the position and divider sit at zero, so entering
      // scan always starts at word 0 after a full divider period.
      r_pos <= '0;
      r_div <= '0;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_dout  <= w_code;
      end else if (w_pop) begin
        r_valid <= 1'b0;
        r_dout  <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_n_pipe
// Description : Self-checking bench for decoder_n_pipe, two configurations
//               (N_IN=2/SCAN_DIV=3 and N_IN=3/SCAN_DIV=2) with scoreboards.
// Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_n_pipe;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  // Instance A: N_IN=2, SCAN_DIV=3
  logic       a_rst_n, a_en, a_iv, a_ir, a_ov, a_or;
  logic [1:0] a_mode, a_din;
  logic [3:0] a_dout;
  // Instance B: N_IN=3, SCAN_DIV=2
  logic       b_rst_n, b_en, b_iv, b_ir, b_ov, b_or;
  logic [1:0] b_mode;
  logic [2:0] b_din;
  logic [7:0] b_dout;

  logic [3:0] qa[$];
  logic [7:0] qb[$];

  decoder_n_pipe #(.N_IN(2), .SCAN_DIV(3)) u_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .mode(a_mode),
    .in_valid(a_iv), .in_ready(a_ir), .din(a_din),
    .out_valid(a_ov), .out_ready(a_or), .dout(a_dout)
  );

  decoder_n_pipe #(.N_IN(3), .SCAN_DIV(2)) u_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .mode(b_mode),
    .in_valid(b_iv), .in_ready(b_ir), .din(b_din),
    .out_valid(b_ov), .out_ready(b_or), .dout(b_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard A: every delivered word must match the oldest expectation
  always @(negedge clk) begin
    logic [3:0] e;
    if (a_ov === 1'b0) chk("a_zero_when_invalid", a_dout, 0);
    if (a_ov && a_or) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL a_extra_word observed=%0h expected=none", a_dout);
      end else begin
        e = qa.pop_front();
        chk("a_sb_word", a_dout, e);
      end
    end
  end

  // Scoreboard B
  always @(negedge clk) begin
    logic [7:0] e;
    if (b_ov === 1'b0) chk("b_zero_when_invalid", b_dout, 0);
    if (b_ov && b_or) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL b_extra_word observed=%0h expected=none", b_dout);
      end else begin
        e = qb.pop_front();
        chk("b_sb_word", b_dout, e);
      end
    end
  end

  task automatic a_send(input logic [1:0] m, input logic [1:0] d, input logic [3:0] exp);
    a_mode = m; a_din = d; a_iv = 1'b1;
    #1 chk("a_in_ready", a_ir, 1);
    qa.push_back(exp);
    step();
    chk("a_lat_valid", a_ov, 1);
    chk("a_lat_dout", a_dout, exp);
    a_iv = 1'b0;
  endtask

  task automatic b_send(input logic [1:0] m, input logic [2:0] d, input logic [7:0] exp);
    b_mode = m; b_din = d; b_iv = 1'b1;
    #1 chk("b_in_ready", b_ir, 1);
    qb.push_back(exp);
    step();
    chk("b_lat_valid", b_ov, 1);
    chk("b_lat_dout", b_dout, exp);
    b_iv = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    a_rst_n = 1'b0; a_en = 1'b1; a_mode = 2'b00; a_iv = 1'b0; a_din = '0; a_or = 1'b1;
    b_rst_n = 1'b0; b_en = 1'b1; b_mode = 2'b00; b_iv = 1'b0; b_din = '0; b_or = 1'b1;
    step();
    step();
    chk("a_rst_valid", a_ov, 0);
    chk("a_rst_dout", a_dout, 0);
    chk("a_rst_ready", a_ir, 0);
    chk("b_rst_dout", b_dout, 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    step();

    // Codes on instance A
    a_send(2'b00, 2'd2, 4'b0100);
    a_send(2'b01, 2'd2, 4'b0111);
    a_send(2'b01, 2'd0, 4'b0001);
    a_send(2'b01, 2'd3, 4'b1111);
    a_send(2'b11, 2'd1, 4'b1101);
    a_send(2'b00, 2'd0, 4'b0001);
    step();
    chk("a_idle_valid", a_ov, 0);

    // Backpressure: hold, mode change on held word, pop+accept
    a_or = 1'b0; a_mode = 2'b00; a_din = 2'd1; a_iv = 1'b1;
    qa.push_back(4'b0010);
    step();
    chk("a_bp_valid", a_ov, 1);
    chk("a_bp_dout", a_dout, 4'b0010);
    a_din = 2'd3;
    #1 chk("a_bp_ready_low", a_ir, 0);
    step();
    chk("a_bp_hold", a_dout, 4'b0010);
    a_mode = 2'b01;
    step();
    chk("a_bp_mode_change_hold", a_dout, 4'b0010);
    a_mode = 2'b00; a_or = 1'b1;
    #1 chk("a_bp_ready_high", a_ir, 1);
    qa.push_back(4'b1000);
    step();
    chk("a_bp_next", a_dout, 4'b1000);
    a_iv = 1'b0;
    step();
    chk("a_bp_drained", a_ov, 0);

    // Scan on instance A, SCAN_DIV=3
    a_mode = 2'b10; a_din = 2'd1; a_iv = 1'b1;
    #1 chk("a_scan_ready", a_ir, 0);
    step(); chk("a_scan_wait1", a_ov, 0);
    step(); chk("a_scan_wait2", a_ov, 0);
    qa.push_back(4'b0001);
    step(); chk("a_scan_first", a_dout, 4'b0001);
    for (int k = 1; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      step(); chk("a_scan_gap1", a_ov, 0);
      step(); chk("a_scan_gap2", a_ov, 0);
      qa.push_back(e);
      step(); chk("a_scan_word", a_dout, e);
    end
    // Stall 5 cycles mid-scan
    a_or = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("a_stall_hold", a_dout, 4'b0001);
    end
    a_or = 1'b1;
    qa.push_back(4'b0010);
    step(); chk("a_stall_successor", a_dout, 4'b0010);
    step(); chk("a_scan_gap1b", a_ov, 0);
    step(); chk("a_scan_gap2b", a_ov, 0);
    qa.push_back(4'b0100);
    step(); chk("a_scan_word_b", a_dout, 4'b0100);

    // Disable while a word is held under stall: flushed
    a_or = 1'b0;
    step(); chk("a_flush_pre", a_dout, 4'b0100);
    a_en = 1'b0;
    #1 chk("a_en_low_ready", a_ir, 0);
    step();
    chk("a_flush_valid", a_ov, 0);
    chk("a_flush_dout", a_dout, 0);
    void'(qa.pop_front());
    a_en = 1'b1; a_or = 1'b1;
    step(); chk("a_reen_wait1", a_ov, 0);
    step(); chk("a_reen_wait2", a_ov, 0);
    qa.push_back(4'b0001);
    step(); chk("a_reen_first", a_dout, 4'b0001);
    a_mode = 2'b00; a_iv = 1'b0;
    step(); chk("a_end_valid", a_ov, 0);

    // Instance B: N_IN=3 codes
    b_send(2'b00, 3'd7, 8'h80);
    b_send(2'b01, 3'd3, 8'h0F);
    b_send(2'b11, 3'd7, 8'h7F);
    b_send(2'b01, 3'd7, 8'hFF);
    step(); chk("b_idle_valid", b_ov, 0);

    // Scan on B (SCAN_DIV=2) with reset mid-scan
    b_mode = 2'b10;
    step(); chk("b_scan_wait", b_ov, 0);
    qb.push_back(8'h01);
    step(); chk("b_scan_first", b_dout, 8'h01);
    step(); chk("b_scan_gap", b_ov, 0);
    qb.push_back(8'h02);
    step(); chk("b_scan_second", b_dout, 8'h02);
    b_or = 1'b0; b_rst_n = 1'b0;
    #1 chk("b_rst_ready", b_ir, 0);
    step();
    chk("b_midrst_valid", b_ov, 0);
    chk("b_midrst_dout", b_dout, 0);
    void'(qb.pop_front());
    b_rst_n = 1'b1; b_or = 1'b1;
    step(); chk("b_restart_wait", b_ov, 0);
    qb.push_back(8'h01);
    step(); chk("b_restart_first", b_dout, 8'h01);
    b_mode = 2'b00;
    step(); chk("b_end_valid", b_ov, 0);

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
